ex_mem_skid_reg: RTL and testbench
==================================

Name: ex_mem_skid_reg

Overview:
- EX/MEM pipeline boundary: captures the ALU result plus the EX-stage control and store data, and presents them to the memory stage.
- Uses a 2-entry skid buffer with valid/ready handshakes on both sides. in_ready is driven from a flop, so the memory stage's stall never forms a combinational path back into the execute stage.
- Also resolves conditional branches from ALUResult bit 0 (the Equal/SLT result).
- Supports a synchronous flush for branch mispredict and trap.

Parameters:
- DATA_WIDTH, 32, width of ALUResult and store data.
- REG_ADDR_WIDTH, 5, width of the destination register index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  EX has a valid instruction.
- in_ready  output  1  buffer can accept; registered.
- ALUResult  input  DATA_WIDTH  ALU output.
- StoreData  input  DATA_WIDTH  rs2 value for stores.
- rd  input  REG_ADDR_WIDTH  destination register.
- RegWrite, MemRead, MemWrite, MemtoReg, Branch  input  1 each  EX-stage control.
- out_valid  output  1  head entry valid.
- out_ready  input  1  MEM stage consumes the head entry.
- out_ALUResult, out_StoreData  output  DATA_WIDTH  head entry data.
- out_rd  output  REG_ADDR_WIDTH  head entry destination.
- out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg  output  1 each  head control, gated by out_valid.
- out_BrTaken  output  1  out_valid & Branch & ALUResult[0] of the head entry.

Behaviour:
- Storage: main entry (M) drives the outputs. Skid entry (S) holds one extra entry captured when the MEM stage stalls in the same cycle that an accept occurs. Valid bits are M_v and S_v.
- in_ready = !S_v, registered (it is a state bit, not logic on out_ready).
- Accept: in_valid & in_ready.
- Consume: out_valid & out_ready.
- Reset (reset=0, asynchronous):
  - M_v=0, S_v=0, all data/control fields 0.
  - out_valid=0, in_ready=1, all out_* = 0.
  - Reset is honoured mid-operation; buffered entries are discarded.
- Per-edge update when flush=0:
  - M empty, accept: M <= input.
  - M full, consume, S empty, accept: M <= input.
  - M full, consume, S full: M <= S, S_v <= 0. No accept is possible, since in_ready=0.
  - M full, no consume, accept: S <= input, S_v <= 1. in_ready drops next cycle.
  - M full, consume, no accept, S empty: M_v <= 0.
  - All other combinations: hold.
- Ordering: strict FIFO; S never bypasses M.
- Flush (flush=1 at the edge):
  - M_v <= 0, S_v <= 0; in_ready=1 next cycle.
  - Any same-cycle accept is dropped; any same-cycle consume still happened downstream.
  - Data fields are not cleared by flush; control outputs are zero through gating.
- Output gating: out_RegWrite/MemRead/MemWrite/MemtoReg/BrTaken are 0 whenever out_valid=0. Data outputs are not gated and hold their last value.
- Latency:
  - An accepted entry appears on outputs 1 cycle later if M is empty or being consumed.
  - Throughput is 1 entry/cycle while out_ready=1.
- Width rules:
  - No arithmetic on data; pure transport.
  - BrTaken uses only bit 0 of the captured ALUResult. Bits [DATA_WIDTH-1:1] are ignored.
- No entry is lost or duplicated under any out_ready pattern. This is a formal invariant: accepts = consumes + occupancy (M_v + S_v), except at flush.

Test Plan:
- Reset: hold reset=0 while driving in_valid=1 and random inputs -> out_valid=0, in_ready=1, all out_* = 0. Deassert, send ALUResult=0x0000_002A, rd=5, RegWrite=1 -> the next cycle shows out_valid=1, out_ALUResult=0x2A, out_rd=5, out_RegWrite=1.
- Streaming: out_ready=1, 8 back-to-back entries with ALUResult=1..8 -> outputs show 1..8 on consecutive cycles; in_ready stays 1.
- Skid: out_ready=0 while sending A=0x10, B=0x20, C=0x30 -> A in M, B in S, in_ready=0 from the cycle after B, C held upstream. Raise out_ready -> outputs A, B, C in order with no loss or duplicate.
- Branch: Branch=1, ALUResult=0x1 -> out_BrTaken=1. ALUResult=0xFFFF_FFFE -> out_BrTaken=0. Branch=0 with ALUResult=1 -> 0.
- Flush: M and S full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_MemWrite=0. The flushed and same-cycle entries never appear.
- Asynchronous reset: mid-stream with S full, pulse reset low between clock edges -> outputs clear immediately without waiting for an edge. After release, the first accepted entry is output correctly.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register built as a 2-entry skid buffer. in_ready comes from a flop,
// so a MEM-stage stall never reaches the execute stage combinationally.
module ex_mem_skid_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [DATA_WIDTH-1:0]     StoreData,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      RegWrite,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic                      MemtoReg,
  input  logic                      Branch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_ALUResult,
  output logic [DATA_WIDTH-1:0]     out_StoreData,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_RegWrite,
  output logic                      out_MemRead,
  output logic                      out_MemWrite,
  output logic                      out_MemtoReg,
  output logic                      out_BrTaken
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu;
    logic [DATA_WIDTH-1:0]     store;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      branch;
  } entry_t;

  entry_t in_entry;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   m_v_q, m_v_d;
  logic   s_v_q, s_v_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, consume;

  assign in_entry = '{alu: ALUResult, store: StoreData, rd: rd, reg_write: RegWrite,
                      mem_read: MemRead, mem_write: MemWrite, mem_to_reg: MemtoReg,
                      branch: Branch};

  assign accept  = in_valid & in_ready_q;
  assign consume = m_v_q & out_ready;

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    if (flush) begin
      // Data is left in place; clearing the valid bits is enough to gate the controls.
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (!m_v_q) begin
      if (accept) begin
        m_d   = in_entry;
        m_v_d = 1'b1;
      end
    end else if (consume) begin
      if (s_v_q) begin
        m_d   = s_q;
        s_v_d = 1'b0;
      end else if (accept) begin
        m_d = in_entry;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (accept) begin
      s_d   = in_entry;
      s_v_d = 1'b1;
    end
    in_ready_d = ~s_v_d;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the entry storage is reset too, so data outputs read zero straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q        <= '0;
      s_q        <= '0;
      m_v_q      <= 1'b0;
      s_v_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_v_q      <= m_v_d;
      s_v_q      <= s_v_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = m_v_q;
  assign out_ALUResult = m_q.alu;
  assign out_StoreData = m_q.store;
  assign out_rd        = m_q.rd;
  assign out_RegWrite  = m_v_q & m_q.reg_write;
  assign out_MemRead   = m_v_q & m_q.mem_read;
  assign out_MemWrite  = m_v_q & m_q.mem_write;
  assign out_MemtoReg  = m_v_q & m_q.mem_to_reg;
  // Branch resolves from the Equal/SLT flag in bit 0 only.
  assign out_BrTaken   = m_v_q & m_q.branch & m_q.alu[0];

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: reset, streaming, skid, branch, flush and async reset.
module tb_ex_mem_skid_reg;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] ALUResult, StoreData, out_ALUResult, out_StoreData;
  logic [4:0]  rd, out_rd;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, Branch;
  logic        out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg, out_BrTaken;

  int checks = 0;
  int errors = 0;

  ex_mem_skid_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .StoreData(StoreData), .rd(rd), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .Branch(Branch),
    .out_valid(out_valid), .out_ready(out_ready), .out_ALUResult(out_ALUResult),
    .out_StoreData(out_StoreData), .out_rd(out_rd), .out_RegWrite(out_RegWrite),
    .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite), .out_MemtoReg(out_MemtoReg),
    .out_BrTaken(out_BrTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] r,
                       input logic rw, input logic mw, input logic br);
    in_valid  = v;
    ALUResult = alu;
    StoreData = ~alu;
    rd        = r;
    RegWrite  = rw;
    MemRead   = 1'b0;
    MemWrite  = mw;
    MemtoReg  = 1'b0;
    Branch    = br;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; ALUResult = $urandom; StoreData = $urandom; rd = 5'($urandom);
    RegWrite = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; MemtoReg = 1'b1; Branch = 1'b1;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu", out_ALUResult, 32'd0);
    check("rst_store", out_StoreData, 32'd0);
    check("rst_rd", 32'(out_rd), 32'd0);
    check("rst_ctrl", {27'd0, out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg, out_BrTaken}, 32'd0);

    reset = 1'b1;
    drive(1'b1, 32'h2A, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_alu", out_ALUResult, 32'h2A);
    check("first_rd", 32'(out_rd), 32'd5);
    check("first_regwrite", 32'(out_RegWrite), 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("gated_regwrite", 32'(out_RegWrite), 32'd0);
    check("data_holds", out_ALUResult, 32'h2A);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 5'd1, 1'b1, 1'b0, 1'b0);
      step();
      check("stream_alu", out_ALUResult, 32'(i));
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("stream_end", 32'(out_valid), 32'd0);

    // Skid: A to M, B to S, C held upstream
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 5'd2, 1'b1, 1'b0, 1'b0);
    step();
    check("skid_a_alu", out_ALUResult, 32'h10);
    check("skid_a_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h20, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    check("skid_b_head", out_ALUResult, 32'h10);
    check("skid_b_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h30, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    check("skid_c_head", out_ALUResult, 32'h10);
    check("skid_c_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("skid_out_b", out_ALUResult, 32'h20);
    check("skid_out_b_rd", 32'(out_rd), 32'd3);
    check("skid_ready_back", 32'(in_ready), 32'd1);
    step();
    check("skid_out_c", out_ALUResult, 32'h30);
    check("skid_out_c_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("skid_empty", 32'(out_valid), 32'd0);

    // Branch resolution from bit 0
    drive(1'b1, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    check("br_taken", 32'(out_BrTaken), 32'd1);
    drive(1'b1, 32'hFFFF_FFFE, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    check("br_bit0_clear", 32'(out_BrTaken), 32'd0);
    check("br_bit0_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("br_not_branch", 32'(out_BrTaken), 32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("br_gated", 32'(out_BrTaken), 32'd0);

    // Flush with M and S full
    out_ready = 1'b0;
    drive(1'b1, 32'h40, 5'd6, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h50, 5'd7, 1'b0, 1'b1, 1'b0);
    step();
    check("fl_full_ready", 32'(in_ready), 32'd0);
    check("fl_full_mw", 32'(out_MemWrite), 32'd1);
    drive(1'b1, 32'h60, 5'd8, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_mw", 32'(out_MemWrite), 32'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    check("fl_no_resurrect", 32'(out_valid), 32'd0);

    // Flush drops a same-cycle accept while in_ready=1
    out_ready = 1'b0;
    drive(1'b1, 32'h70, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    check("fl2_head", out_ALUResult, 32'h70);
    drive(1'b1, 32'h80, 5'd10, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    check("fl2_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("fl2_dropped", 32'(out_valid), 32'd0);
    check("fl2_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset between edges with S full
    drive(1'b1, 32'h90, 5'd11, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'hA0, 5'd12, 1'b1, 1'b1, 1'b0);
    step();
    check("ar_pre_ready", 32'(in_ready), 32'd0);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_alu", out_ALUResult, 32'd0);
    check("ar_mw", 32'(out_MemWrite), 32'd0);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hB0, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    check("ar_after_valid", 32'(out_valid), 32'd1);
    check("ar_after_alu", out_ALUResult, 32'hB0);
    check("ar_after_rd", 32'(out_rd), 32'd7);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("ar_after_drain", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
